// File: rtl/pp_interleave_buffer_ctrl_pkg.sv
//============================================================================
// Module      : pp_buffer_pkg
// Description : Shared types and helpers for the ping-pong interleave buffer
//               controller: top-level state encoding, bank-select encoding
//               and block-length / bank-mask helpers.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

package pp_buffer_pkg;

    // Top-level controller state
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } top_state_t;

    // Bank selector for the two external DPR banks
    typedef enum logic [0:0] {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_t;

    localparam int DEF_ROWS      = 12;
    localparam int DEF_COLS      = 16;
    localparam int DEF_BLOCK_LEN = DEF_ROWS * DEF_COLS;

    function automatic int block_len(input int rows, input int cols);
        return rows * cols;
    endfunction

    // One-hot position of a bank inside the 2-bit full-flag vector
    function automatic logic [1:0] bank_mask(input bank_t b);
        return (b == BANK_A) ? 2'b01 : 2'b10;
    endfunction

    function automatic bank_t other_bank(input bank_t b);
        return (b == BANK_A) ? BANK_B : BANK_A;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pp_interleave_buffer_ctrl_if.sv
//============================================================================
// Module      : pp_interleave_buffer_ctrl_if
// Description : Bundle of the buffer controller's handshake and bank signals.
//               Ports:
//                 in_valid/in_ready/in_data : input stream handshake
//                 transpose                 : read-order select (per block)
//                 out_valid/out_ready/out_data/out_last : output stream
//                 wren_A/wren_B/wraddr/wrdata : bank write port
//                 rden_A/rden_B/rdaddr        : bank read port
//                 q_A/q_B                     : bank read data (1-cycle)
//               master = environment side, slave = controller side.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

interface pp_interleave_buffer_ctrl_if #(
    parameter int DATA_W = 1,
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              transpose;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              wren_A;
    logic              wren_B;
    logic [ADDR_W-1:0] wraddr;
    logic [DATA_W-1:0] wrdata;
    logic              rden_A;
    logic              rden_B;
    logic [ADDR_W-1:0] rdaddr;
    logic [DATA_W-1:0] q_A;
    logic [DATA_W-1:0] q_B;

    modport master (
        output in_valid, in_data, transpose, out_ready, q_A, q_B,
        input  in_ready, out_valid, out_data, out_last,
               wren_A, wren_B, wraddr, wrdata, rden_A, rden_B, rdaddr
    );

    modport slave (
        input  in_valid, in_data, transpose, out_ready, q_A, q_B,
        output in_ready, out_valid, out_data, out_last,
               wren_A, wren_B, wraddr, wrdata, rden_A, rden_B, rdaddr
    );

endinterface

`default_nettype wire

// File: rtl/pp_interleave_buffer_ctrl_rd_addr_gen.sv
//============================================================================
// Module      : pp_rd_addr_gen
// Description : Read address generator for one block. Linear mode emits
//               0..BLOCK_LEN-1; transpose mode emits r*COLS + c with the row
//               index running fastest, built from an accumulator (+COLS per
//               step, reload c+1 on row wrap) instead of a multiplier.
//               Ports:
//                 clk, reset  : clock, async active-high reset
//                 i_start     : restart at word 0 of a new block
//                 i_step      : advance to the next word (a read is issued)
//                 i_transpose : read-order request, latched at word 0
//                 o_addr      : address of the current word
//                 o_last      : current word is the final word of the block
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module pp_rd_addr_gen #(
    parameter int ROWS   = 12,
    parameter int COLS   = 16,
    parameter int ADDR_W = $clog2(ROWS * COLS)
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_start,
    input  wire logic              i_step,
    input  wire logic              i_transpose,
    output logic      [ADDR_W-1:0] o_addr,
    output logic                   o_last
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(ROWS * COLS - 1);
    localparam logic [ADDR_W-1:0] c_COL_STEP = ADDR_W'(COLS);
    localparam logic [ROW_W-1:0]  c_LAST_ROW = ROW_W'(ROWS - 1);

    logic [ADDR_W-1:0] r_idx;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [ADDR_W-1:0] r_acc;
    logic              r_mode;

    logic w_first;
    logic w_mode;

    // Mode is taken live on word 0 and held from then on for the block.
    // Word 0 is address 0 in either mode, so the output is unaffected.
    assign w_first = (r_idx == '0);
    assign w_mode  = w_first ? i_transpose : r_mode;
    assign o_addr  = w_mode ? r_acc : r_idx;
    assign o_last  = (r_idx == c_LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx  <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_acc  <= '0;
            r_mode <= 1'b0;
        end else if (i_start) begin
            r_idx  <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_acc  <= '0;
            r_mode <= 1'b0;
        end else if (i_step) begin
            r_mode <= w_mode;
            if (o_last) begin
                r_idx <= '0;
                r_row <= '0;
                r_col <= '0;
                r_acc <= '0;
            end else begin
                r_idx <= r_idx + ADDR_W'(1);
                // Row/column counters advance in both modes; only the
                // accumulator output is selected in transpose mode.
                if (r_row == c_LAST_ROW) begin
                    r_row <= '0;
                    r_col <= r_col + COL_W'(1);
                    r_acc <= ADDR_W'(r_col) + ADDR_W'(1);
                end else begin
                    r_row <= r_row + ROW_W'(1);
                    r_acc <= r_acc + c_COL_STEP;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pp_interleave_buffer_ctrl.sv
//============================================================================
// Module      : pp_interleave_buffer_ctrl
// Description : Ping-pong buffer controller for two external single-clock
//               DPR banks. After reset both banks are zero-filled (CLEAR),
//               then one bank is filled from the input stream while the
//               other is drained to the output stream, in linear or
//               row/column-transposed order selected per block.
//               Ports:
//                 clk   : clock, rising edge
//                 reset : asynchronous, active-high
//                 bus   : slave modport of pp_interleave_buffer_ctrl_if
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module pp_interleave_buffer_ctrl
    import pp_buffer_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int DATA_W = 1,
    parameter int ADDR_W = $clog2(ROWS * COLS)
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    pp_interleave_buffer_ctrl_if.slave bus
);

    localparam int                c_BLOCK_LEN = block_len(ROWS, COLS);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(c_BLOCK_LEN - 1);

    top_state_t        r_state;
    top_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_wr_cnt;
    bank_t             r_wr_sel;
    bank_t             r_rd_sel;
    bank_t             r_q_sel;
    logic [1:0]        r_full;
    logic              r_out_valid;
    logic              r_out_last;

    logic              w_clearing;
    logic              w_in_ready;
    logic              w_wr_acc;
    logic              w_issue;
    logic [1:0]        w_full_set;
    logic [1:0]        w_full_clr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_rd_last;

    //------------------------------------------------------------------
    // Read address generator
    //------------------------------------------------------------------
    pp_rd_addr_gen #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .ADDR_W (ADDR_W)
    ) u_rd_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .i_start     (r_state == CLEAR),
        .i_step      (w_issue),
        .i_transpose (bus.transpose),
        .o_addr      (w_rd_addr),
        .o_last      (w_rd_last)
    );

    //------------------------------------------------------------------
    // FSM state register
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //------------------------------------------------------------------
    // Next state, handshakes and full-flag updates
    //------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_clearing  = 1'b0;
        w_in_ready  = 1'b0;
        w_wr_acc    = 1'b0;
        w_issue     = 1'b0;
        w_full_set  = 2'b00;
        w_full_clr  = 2'b00;
        case (r_state)
            CLEAR: begin
                // Gated by reset so the bank enables drop the moment
                // reset is asserted, not at the next edge.
                w_clearing = !reset;
                if (r_wr_cnt == c_LAST_ADDR) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_in_ready = ~|(r_full & bank_mask(r_wr_sel));
                w_wr_acc   = w_in_ready && bus.in_valid;
                w_issue    = (|(r_full & bank_mask(r_rd_sel))) &&
                             (!r_out_valid || bus.out_ready);
                if (w_wr_acc && (r_wr_cnt == c_LAST_ADDR)) begin
                    w_full_set = bank_mask(r_wr_sel);
                end
                if (w_issue && w_rd_last) begin
                    w_full_clr = bank_mask(r_rd_sel);
                end
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Writer, reader bank selects, full flags and output register
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_cnt    <= '0;
            r_wr_sel    <= BANK_A;
            r_rd_sel    <= BANK_A;
            r_q_sel     <= BANK_A;
            r_full      <= 2'b00;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            // The write counter doubles as the CLEAR address; it wraps to 0
            // exactly as CLEAR hands over to RUN.
            if ((r_state == CLEAR) || w_wr_acc) begin
                r_wr_cnt <= (r_wr_cnt == c_LAST_ADDR) ? '0 : r_wr_cnt + ADDR_W'(1);
            end
            if (w_wr_acc && (r_wr_cnt == c_LAST_ADDR)) begin
                r_wr_sel <= other_bank(r_wr_sel);
            end
            if (w_issue && w_rd_last) begin
                r_rd_sel <= other_bank(r_rd_sel);
            end
            // Set and clear never target the same bank in one cycle.
            r_full <= (r_full | w_full_set) & ~w_full_clr;

            if (w_issue) begin
                r_out_valid <= 1'b1;
                r_out_last  <= w_rd_last;
                r_q_sel     <= r_rd_sel;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    //------------------------------------------------------------------
    // Bank and stream outputs
    //------------------------------------------------------------------
    assign bus.in_ready  = w_in_ready;
    assign bus.wren_A    = w_clearing || (w_wr_acc && (r_wr_sel == BANK_A));
    assign bus.wren_B    = w_clearing || (w_wr_acc && (r_wr_sel == BANK_B));
    assign bus.wraddr    = r_wr_cnt;
    assign bus.wrdata    = (r_state == CLEAR) ? '0 : bus.in_data;
    assign bus.rden_A    = w_issue && (r_rd_sel == BANK_A);
    assign bus.rden_B    = w_issue && (r_rd_sel == BANK_B);
    assign bus.rdaddr    = w_rd_addr;
    // Banks hold q while not read, so out_data is stable during a stall.
    assign bus.out_data  = (r_q_sel == BANK_A) ? bus.q_A : bus.q_B;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;

endmodule

`default_nettype wire

// File: tb/tb_pp_interleave_buffer_ctrl.sv
//============================================================================
// Module      : tb_pp_interleave_buffer_ctrl
// Description : Self-checking bench for pp_interleave_buffer_ctrl with a
//               behavioural model of the two DPR banks.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pp_interleave_buffer_ctrl;

    localparam int ROWS   = 12;
    localparam int COLS   = 16;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int BL     = ROWS * COLS;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pp_interleave_buffer_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    pp_interleave_buffer_ctrl #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .DATA_W (DATA_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Bank model: synchronous write, 1-cycle read, q held while rden = 0
    logic [DATA_W-1:0] mem_a [BL];
    logic [DATA_W-1:0] mem_b [BL];
    logic              mem_scrub = 1'b1;

    always @(posedge clk) begin
        if (mem_scrub) begin
            for (int k = 0; k < BL; k++) begin
                mem_a[k] <= 16'hA5A5;
                mem_b[k] <= 16'h5A5A;
            end
        end else begin
            if (bus.wren_A && (int'(bus.wraddr) < BL)) mem_a[bus.wraddr] <= bus.wrdata;
            if (bus.wren_B && (int'(bus.wraddr) < BL)) mem_b[bus.wraddr] <= bus.wrdata;
            if (bus.rden_A && (int'(bus.rdaddr) < BL)) bus.q_A <= mem_a[bus.rdaddr];
            if (bus.rden_B && (int'(bus.rdaddr) < BL)) bus.q_B <= mem_b[bus.rdaddr];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    int cyc = 0;
    int n_in = 0;
    logic hold_valid = 1'b0;
    logic rdy_level = 1'b1;
    int rdy_period = 0;
    logic [DATA_W-1:0] src_q [$];
    logic [DATA_W-1:0] got_q [$];
    logic              last_q [$];

    int stall_viol = 0;
    int n_stall = 0;
    logic prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic prev_last = 1'b0;

    // One clock cycle: account the transfers happening at the coming edge,
    // then drive the next cycle's inputs 1 ns after the edge.
    task automatic step();
        if (bus.in_valid && bus.in_ready) begin
            if (src_q.size() != 0) src_q.delete(0);
            n_in++;
        end
        if (bus.out_valid && bus.out_ready) begin
            got_q.push_back(bus.out_data);
            last_q.push_back(bus.out_last);
        end
        if (bus.out_valid && !bus.out_ready && (bus.rden_A || bus.rden_B)) stall_viol++;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_last  = bus.out_last;
        @(posedge clk);
        #1;
        cyc++;
        if (prev_stall) begin
            n_stall++;
            if (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last)
                stall_viol++;
        end
        bus.in_valid  = hold_valid || (src_q.size() != 0);
        bus.in_data   = (src_q.size() != 0) ? src_q[0] : '0;
        bus.out_ready = (rdy_period == 0) ? rdy_level : ((cyc % rdy_period) != 0);
        #1;
    endtask

    task automatic run_until(input int want, input int budget);
        for (int k = 0; k < budget && got_q.size() < want; k++) step();
    endtask

    task automatic start_stream();
        bus.in_valid  = (src_q.size() != 0);
        bus.in_data   = (src_q.size() != 0) ? src_q[0] : '0;
        bus.out_ready = rdy_level;
        #1;
    endtask

    task automatic reset_cleanup();
        src_q.delete();
        got_q.delete();
        last_q.delete();
        hold_valid = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    //------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.transpose = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mem_scrub = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b want=0", bus.in_ready);
        else n_pass++;
        n_checks++;
        if ({bus.out_valid, bus.out_last} !== 2'b00)
            $display("FAIL reset_out got valid,last=%b want=00", {bus.out_valid, bus.out_last});
        else n_pass++;
        n_checks++;
        if ({bus.wren_A, bus.wren_B, bus.rden_A, bus.rden_B} !== 4'b0000)
            $display("FAIL reset_enables got=%b want=0000", {bus.wren_A, bus.wren_B, bus.rden_A, bus.rden_B});
        else n_pass++;
        n_checks++;
        if ({bus.wraddr, bus.rdaddr} !== 16'd0)
            $display("FAIL reset_addr got wr=%0d rd=%0d want 0/0", bus.wraddr, bus.rdaddr);
        else n_pass++;
    endtask

    //------------------------------------------------------------------
    task automatic test_clear();
        int viol = 0;
        int nz = 0;
        hold_valid = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        reset = 1'b0;
        #1;
        for (int k = 0; k < BL; k++) begin
            if (bus.in_ready !== 1'b0 || bus.wren_A !== 1'b1 || bus.wren_B !== 1'b1 ||
                bus.wraddr !== ADDR_W'(k) || bus.wrdata !== '0 ||
                bus.rden_A !== 1'b0 || bus.rden_B !== 1'b0) viol++;
            step();
        end
        n_checks++;
        if (viol !== 0) $display("FAIL clear_cycles got %0d bad cycles want 0", viol);
        else n_pass++;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL clear_first_ready got=%b want=1 at cycle %0d", bus.in_ready, BL);
        else n_pass++;
        hold_valid = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        for (int k = 0; k < BL; k++) begin
            if (mem_a[k] !== '0) nz++;
            if (mem_b[k] !== '0) nz++;
        end
        n_checks++;
        if (nz !== 0) $display("FAIL clear_banks_zero got %0d nonzero words want 0", nz);
        else n_pass++;
    endtask

    //------------------------------------------------------------------
    task automatic test_linear_stream();
        int acc191 = -1;
        int first_ov = -1;
        int bubbles = 0;
        int bad = 0;
        int bad_last = 0;
        reset_cleanup();
        bus.transpose = 1'b0;
        rdy_level = 1'b1; rdy_period = 0;
        for (int i = 0; i < 3 * BL; i++) src_q.push_back(DATA_W'(i));
        start_stream();
        for (int k = 0; k < 3000 && got_q.size() < 3 * BL; k++) begin
            if (bus.in_valid && bus.in_ready && bus.in_data == 16'd191) acc191 = cyc;
            if (bus.out_valid && first_ov < 0) first_ov = cyc;
            if (first_ov >= 0 && !bus.out_valid) bubbles++;
            step();
        end
        n_checks++;
        if (acc191 < 0 || (first_ov - acc191) !== 2)
            $display("FAIL linear_latency got %0d cycles want 2", first_ov - acc191);
        else n_pass++;
        n_checks++;
        if (bubbles !== 0) $display("FAIL linear_bubbles got %0d want 0", bubbles);
        else n_pass++;
        n_checks++;
        if (got_q.size() !== 3 * BL) $display("FAIL linear_count got %0d want %0d", got_q.size(), 3 * BL);
        else n_pass++;
        for (int i = 0; i < got_q.size(); i++) begin
            if (got_q[i] !== DATA_W'(i)) bad++;
            if (last_q[i] !== ((i % BL) == BL - 1)) bad_last++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL linear_data got %0d wrong words want 0", bad);
        else n_pass++;
        n_checks++;
        if (bad_last !== 0) $display("FAIL linear_last got %0d wrong flags want 0", bad_last);
        else n_pass++;
    endtask

    //------------------------------------------------------------------
    task automatic test_transpose();
        int bad = 0;
        int bad_last = 0;
        reset_cleanup();
        bus.transpose = 1'b1;
        rdy_level = 1'b1; rdy_period = 0;
        for (int i = 0; i < BL; i++) src_q.push_back(DATA_W'(i));
        start_stream();
        run_until(BL, 1000);
        n_checks++;
        if (got_q.size() !== BL) $display("FAIL transpose_count got %0d want %0d", got_q.size(), BL);
        else n_pass++;
        for (int i = 0; i < got_q.size(); i++) begin
            if (got_q[i] !== DATA_W'((i % ROWS) * COLS + (i / ROWS))) bad++;
            if (last_q[i] !== (i == BL - 1)) bad_last++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL transpose_data got %0d wrong words want 0", bad);
        else n_pass++;
        n_checks++;
        if (got_q.size() > 12 && (got_q[1] !== 16'd16 || got_q[11] !== 16'd176 || got_q[12] !== 16'd1))
            $display("FAIL transpose_wrap got %0d,%0d,%0d want 16,176,1", got_q[1], got_q[11], got_q[12]);
        else n_pass++;
        n_checks++;
        if (bad_last !== 0) $display("FAIL transpose_last got %0d wrong flags want 0", bad_last);
        else n_pass++;
    endtask

    //------------------------------------------------------------------
    task automatic test_mode_toggle();
        int bad1 = 0;
        int bad2 = 0;
        reset_cleanup();
        bus.transpose = 1'b1;
        rdy_level = 1'b1; rdy_period = 0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < BL; i++) src_q.push_back(DATA_W'(i));
        start_stream();
        for (int k = 0; k < 2000 && got_q.size() < 2 * BL; k++) begin
            step();
            if (got_q.size() >= 50) bus.transpose = 1'b0;
        end
        n_checks++;
        if (got_q.size() !== 2 * BL) $display("FAIL toggle_count got %0d want %0d", got_q.size(), 2 * BL);
        else n_pass++;
        for (int i = 0; i < got_q.size(); i++) begin
            if (i < BL) begin
                if (got_q[i] !== DATA_W'((i % ROWS) * COLS + (i / ROWS))) bad1++;
            end else begin
                if (got_q[i] !== DATA_W'(i - BL)) bad2++;
            end
        end
        n_checks++;
        if (bad1 !== 0) $display("FAIL toggle_cur_block got %0d wrong words want 0", bad1);
        else n_pass++;
        n_checks++;
        if (bad2 !== 0) $display("FAIL toggle_next_block got %0d wrong words want 0", bad2);
        else n_pass++;
    endtask

    //------------------------------------------------------------------
    task automatic test_back_to_back_stall();
        int bad = 0;
        int bad_last = 0;
        reset_cleanup();
        bus.transpose = 1'b0;
        rdy_level = 1'b0; rdy_period = 0;
        n_in = 0; stall_viol = 0; n_stall = 0;
        for (int i = 0; i < 3 * BL; i++) src_q.push_back(DATA_W'(1000 + i));
        start_stream();
        repeat (400) step();
        n_checks++;
        if (n_in !== 2 * BL) $display("FAIL stall_accepted got %0d want %0d", n_in, 2 * BL);
        else n_pass++;
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
            $display("FAIL stall_flags got in_ready=%b out_valid=%b want 0/1", bus.in_ready, bus.out_valid);
        else n_pass++;
        n_checks++;
        if ((n_stall > 100) !== 1'b1) $display("FAIL stall_cycles got %0d want >100", n_stall);
        else n_pass++;
        rdy_level = 1'b1; rdy_period = 3;
        run_until(3 * BL, 3000);
        n_checks++;
        if (got_q.size() !== 3 * BL) $display("FAIL stall_count got %0d want %0d", got_q.size(), 3 * BL);
        else n_pass++;
        for (int i = 0; i < got_q.size(); i++) begin
            if (got_q[i] !== DATA_W'(1000 + i)) bad++;
            if (last_q[i] !== ((i % BL) == BL - 1)) bad_last++;
        end
        n_checks++;
        if (bad !== 0 || bad_last !== 0)
            $display("FAIL stall_data got %0d bad words %0d bad flags want 0/0", bad, bad_last);
        else n_pass++;
        n_checks++;
        if (stall_viol !== 0) $display("FAIL stall_stable got %0d unstable cycles want 0", stall_viol);
        else n_pass++;
        rdy_period = 0;
    endtask

    //------------------------------------------------------------------
    task automatic test_reset_mid();
        int ov_seen = 0;
        int nz = 0;
        int bad = 0;
        // Mid-write: partial block in progress
        reset_cleanup();
        rdy_level = 1'b1; rdy_period = 0;
        bus.transpose = 1'b0;
        for (int i = 0; i < 100; i++) src_q.push_back(DATA_W'(7000 + i));
        start_stream();
        repeat (60) step();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_last, bus.wren_A, bus.wren_B,
             bus.rden_A, bus.rden_B, bus.wraddr, bus.rdaddr} !== 23'd0)
            $display("FAIL reset_mid_write got nonzero outputs wraddr=%0d wren=%b%b want all 0",
                     bus.wraddr, bus.wren_A, bus.wren_B);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        reset_cleanup();
        reset = 1'b0;
        #1;
        // Mid-read: one block draining, next block being written
        repeat (BL) step();
        for (int i = 0; i < BL + 60; i++) src_q.push_back(DATA_W'(8000 + i));
        start_stream();
        run_until(50, 1000);
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_last, bus.wren_A, bus.wren_B,
             bus.rden_A, bus.rden_B, bus.wraddr, bus.rdaddr} !== 23'd0)
            $display("FAIL reset_mid_read got nonzero outputs out_valid=%b rdaddr=%0d want all 0",
                     bus.out_valid, bus.rdaddr);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        reset_cleanup();
        reset = 1'b0;
        #1;
        for (int k = 0; k < BL; k++) begin
            if (bus.out_valid) ov_seen++;
            step();
        end
        n_checks++;
        if (ov_seen !== 0 || got_q.size() !== 0)
            $display("FAIL reset_no_stale got %0d valid cycles want 0", ov_seen);
        else n_pass++;
        for (int k = 0; k < BL; k++) begin
            if (mem_a[k] !== '0) nz++;
            if (mem_b[k] !== '0) nz++;
        end
        n_checks++;
        if (nz !== 0 || bus.in_ready !== 1'b1)
            $display("FAIL reset_reclear got %0d nonzero words in_ready=%b want 0/1", nz, bus.in_ready);
        else n_pass++;
        for (int i = 0; i < BL; i++) src_q.push_back(DATA_W'(9000 + i));
        start_stream();
        run_until(BL, 1000);
        for (int i = 0; i < got_q.size(); i++)
            if (got_q[i] !== DATA_W'(9000 + i)) bad++;
        n_checks++;
        if (got_q.size() !== BL || bad !== 0)
            $display("FAIL reset_fresh_block got %0d words %0d wrong want %0d/0", got_q.size(), bad, BL);
        else n_pass++;
    endtask

    //------------------------------------------------------------------
    initial begin
        test_reset();
        test_clear();
        test_linear_stream();
        test_transpose();
        test_mode_toggle();
        test_back_to_back_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/pp_interleave_buffer_ctrl.md
# pp_interleave_buffer_ctrl

Parametrised ping-pong buffer controller for the channel-coding chain: generalises the fixed 192-bit, 1-bit-wide ping-pong control. It drives two external single-clock DPR banks (A/B) and fills one bank while draining the other. Input and output use valid/ready handshakes with full backpressure, and read order is per-block selectable between linear and row/column transposed (block interleaving). It sits between the encoder stage and the interleaver/modulator input.

## Interface
- ROWS, 12, interleaver rows; must be ≥2
- COLS, 16, interleaver columns; must be ≥2; BLOCK_LEN = ROWS*COLS (default 192)
- DATA_W, 1, word width
- ADDR_W, $clog2(ROWS*COLS), derived; do not override
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid / in_ready  in / out  1  input handshake; word accepted when both are 1
- in_data  in  DATA_W  input word
- transpose  in  1  read-order select: 0 linear, 1 column-wise
- out_valid / out_ready  out / in  1  output handshake
- out_data  out  DATA_W  output word
- out_last  out  1  marks the final word of a block
- wren_A, wren_B  out  1  bank write enables
- wraddr  out  ADDR_W  shared write address
- wrdata  out  DATA_W  shared write data
- rden_A, rden_B  out  1  bank read enables
- rdaddr  out  ADDR_W  shared read address
- q_A, q_B  in  DATA_W  bank read data; 1-cycle latency; each bank holds q while its rden=0

## Operation
- Top FSM: CLEAR → RUN. RUN is left only on reset.
- CLEAR:
  - Runs for BLOCK_LEN cycles.
  - wren_A = wren_B = 1, wrdata = 0, wraddr counts 0..BLOCK_LEN-1.
  - in_ready = 0, no reads issued.
- RUN writer:
  - Holds wr_sel (starts at A) and wr_cnt.
  - in_ready = !full[wr_sel].
  - On an accepted word: wren of wr_sel = 1, wraddr = wr_cnt, wrdata = in_data.
  - At wr_cnt = BLOCK_LEN-1: set full[wr_sel], toggle wr_sel, wr_cnt wraps to 0.
- RUN reader:
  - Holds rd_sel (starts at A).
  - Issues a read when full[rd_sel] && (!out_valid || out_ready).
  - Issue means: rden of rd_sel = 1, rdaddr from the address generator.
  - On issue of the final address: clear full[rd_sel], toggle rd_sel.
- Address generator:
  - Linear mode: addr = i.
  - Transpose mode: addr = r*COLS + c, with r iterating fastest. Implemented as an accumulator: +COLS per step; on r wrap, load c+1. No multiplier.
  - transpose is sampled at issue of word 0 of each block and held for that block.
- Output side:
  - out_valid is registered: set on the cycle after an issue, cleared on out_ready when no new issue occurs.
  - out_data = q of q_sel, where q_sel is rd_sel registered at issue.
  - out_last is registered alongside and is 1 for the final word of the block.
- Full-flag invariants:
  - The writer never writes a full bank; the reader never reads a non-full bank. So a bank is never written and read in the same cycle.
  - Setting full on one bank and clearing it on the other in the same cycle are independent.
  - Both flags set → in_ready = 0 until the reader clears one.
- Reset values: state = CLEAR, all counters 0, wr_sel = rd_sel = A, full = 00.
- Outputs after reset: in_ready = 0, out_valid = 0, out_last = 0, all wren/rden = 0, addresses 0.
- Reset mid-block discards all buffered data and re-runs CLEAR.

## Timing
- Throughput: 1 word/cycle in and out, sustained, when out_ready = 1.
- First in_ready = 1 on cycle BLOCK_LEN after reset deasserts.
- Block latency: last word of a block accepted at cycle t → full set at t+1 → first read issued at t+1 → out_valid = 1 at t+2.
- Output stall: out_valid && !out_ready blocks issue. rden stays 0, so q, out_data, and out_last stay stable.
- Output data is never lost or duplicated across stalls.
- in_ready responds combinationally to the full flags only, never to in_valid.

## Structure
- Package pp_buffer_pkg: top-state enum (CLEAR, RUN), bank-select enum (BANK_A, BANK_B), and a BLOCK_LEN localparam helper.
- Sub-module pp_rd_addr_gen: row/column counters plus accumulator. Inputs: start, step, transpose. Outputs: addr and last.
- Top module holds the FSM, the writer, the full flags, and the output register.

## Test plan
- Reset release, in_valid held 1: in_ready stays 0 for 192 cycles; both banks' 192 words read back 0 → then in_ready = 1.
- Stream 3 blocks (values 0..191, 192..383, ...) with linear mode and out_ready = 1: out_valid first at 2 cycles after word 191 is accepted; output 0..191 in order; out_last on word 191 of each block; zero bubbles.
- transpose = 1, ROWS = 12, COLS = 16, data = address: output sequence is 0, 16, 32, …, 176, 1, 17, …, 191.
- out_ready = 0 for 400 cycles while input streams: in_ready drops after 384 accepted words; on release, output resumes with no loss or duplication and out_data stable during the stall.
- Toggle transpose mid-block: the current block keeps its mode; the next block uses the new value.
- Assert reset mid-write and mid-read: outputs return to their reset values immediately; CLEAR restarts; no stale words are output afterwards.
